id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Instruction-decode stage; the consumer of the 64-bit IF_ID word produced by the fetch stage.
- Splits IF_ID into PC_Plus4 and instruction, reads the external register file, and decodes control.
- Resolves J/JAL/JR/JALR, detects load-use and JR hazards, drives IF_Pause/IF_Flush back to fetch, and registers everything into the ID_EX pipeline outputs.

Parameters:
- LINK_REG, 31, destination register index for jal.
- NOP_WORD, 32'h0000_0000, instruction value treated as a bubble (the flushed IF_ID payload).

Ports:
- clk  input  1  pipeline clock; all state on posedge.
- reset  input  1  asynchronous, active-high reset.
- IF_ID  input  64  {PC_Plus4[31:0], Instruction[31:0]} from fetch.
- rf_rs_addr  output  5  register-file read address A = Instruction[25:21] (combinational).
- rf_rt_addr  output  5  read address B = Instruction[20:16] (combinational).
- rs_data  input  32  register-file read data A (combinational, write-first).
- rt_data  input  32  register-file read data B.
- ex_branch_taken  input  1  EX stage resolved a taken beq/bne this cycle.
- mem_reg_write  input  1  MEM-stage instruction writes a register.
- mem_rd  input  5  MEM-stage destination.
- IF_Pause  output  1  hold PC and IF_ID (combinational).
- IF_Flush  output  1  load bubble into IF_ID (combinational).
- id_pcsrc  output  2  {JR, J}; ORed with EX's B bit into PCSrc at top level.
- jump_address  output  32  {PC_Plus4[31:28], Instruction[25:0], 2'b00}.
- jr_address  output  32  rs_data.
- ex_pc_plus4  output  32  registered PC_Plus4.
- ex_rs_data / ex_rt_data  output  32 each  registered operands.
- ex_imm  output  32  registered immediate.
- ex_rs / ex_rt / ex_rd  output  5 each  registered register indices; ex_rd is the final destination.
- ex_op / ex_funct  output  6 each  raw opcode/funct for EX ALU control.
- ex_ctrl  output  8  {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, Branch, LinkPC, BNE}.
- ill_instr  output  1  registered one-cycle pulse on an undefined opcode or funct.

Behaviour:
- Reset: every ex_* output, ex_ctrl and ill_instr go to 0 asynchronously. Combinational outputs follow their inputs.
- Decode, by opcode:
  - 00 R-type: RegWrite, rd dest. funct 08 jr: no RegWrite. funct 09 jalr: RegWrite, LinkPC, rd dest.
  - 02 j: ctrl 0. 03 jal: RegWrite, LinkPC, dest LINK_REG.
  - 04 beq / 05 bne: Branch, sign-extended imm; 05 also sets BNE.
  - 08, 09, 0a, 0b: ALUSrc, RegWrite, sign-extended imm, rt dest.
  - 0c, 0d, 0e: ALUSrc, RegWrite, zero-extended imm, rt dest.
  - 0f lui: ALUSrc, RegWrite, imm = {Instruction[15:0], 16'h0}.
  - 23 lw: MemRead, MemToReg, RegWrite, ALUSrc, sign-extended imm.
  - 2b sw: MemWrite, ALUSrc, sign-extended imm.
  - Anything else: ctrl 0 and ill_instr=1 next cycle.
  - Instruction==NOP_WORD: ctrl 0, ill_instr=0.
  - A destination of 0 forces RegWrite=0.
- Load-use stall: ex_ctrl.MemRead=1, ex_rt≠0, and ex_rt equals a source used by the current instruction (rs always; rt for R-type, beq, bne, sw).
  - Drive IF_Pause=1.
  - Load a bubble into ID_EX: ex_ctrl=0, ex_rd=0, other ex_* don't-care but zeroed.
  - id_pcsrc=0.
- JR hazard: current is jr/jalr and rs≠0 matches either (ex_ctrl.RegWrite and ex_rd) or (mem_reg_write and mem_rd). Same response as the load-use stall. It lasts at most 2 cycles.
- Jump: with no stall, j/jal give id_pcsrc=01 and IF_Flush=1; jr/jalr give id_pcsrc=10 and IF_Flush=1. The jump instruction itself still enters ID_EX, because jal/jalr need the link write.
- Priority: ex_branch_taken > stall > jump. On ex_branch_taken:
  - IF_Flush=1, IF_Pause=0, id_pcsrc=00.
  - ID_EX loads a bubble; the current ID instruction is squashed.
- Stall and flush are never asserted together.
- Latency: ID_EX updates one cycle after IF_ID is presented. No internal buffering beyond the ID_EX register.
- Reset mid-stall: all pause/flush state clears immediately. There are no multi-cycle FSM states; stall duration is derived purely from the ID_EX and MEM state.

Test Plan:
- `lw $2,0($1)` then `add $3,$2,$4` → 1 cycle IF_Pause=1; ID_EX bubble (ex_ctrl=0); add enters ID_EX the following cycle with ex_rd=3.
- `jal` at PC 0x0000_0040 (PC_Plus4 0x44), instr[25:0]=0x100 → jump_address=0x0000_0400, id_pcsrc=01, IF_Flush=1; next cycle ex_rd=31, ex_ctrl.LinkPC=1, ex_pc_plus4=0x44.
- `addi $5,...` then `jr $5` → jr stalls 2 cycles (EX then MEM match); third cycle id_pcsrc=10, jr_address=rs_data.
- `jr $5` in ID with ex_branch_taken=1 the same cycle → id_pcsrc=00, IF_Flush=1, ID_EX bubble.
- `ori $1,$0,0xFFFF` → ex_imm=0x0000_FFFF; `addi` with imm 0xFFFF → ex_imm=0xFFFF_FFFF; `lui` with imm 0x1234 → ex_imm=0x1234_0000.
- Opcode 0x3F → ill_instr pulses 1 cycle with ex_ctrl=0; reset asserted mid-stall → all ex_* outputs 0 at once and IF_Pause follows the bubble state.

Source files
------------

// File: rtl/id_stage.sv
// Instruction-decode stage: splits IF_ID, decodes control, resolves jumps,
// detects load-use / jr hazards and registers the result into ID_EX.
module id_stage #(
    parameter logic [4:0]  LINK_REG = 5'd31,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] IF_ID,
    output logic [4:0]  rf_rs_addr,
    output logic [4:0]  rf_rt_addr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        ex_branch_taken,
    input  logic        mem_reg_write,
    input  logic [4:0]  mem_rd,
    output logic        IF_Pause,
    output logic        IF_Flush,
    output logic [1:0]  id_pcsrc,
    output logic [31:0] jump_address,
    output logic [31:0] jr_address,
    output logic [31:0] ex_pc_plus4,
    output logic [31:0] ex_rs_data,
    output logic [31:0] ex_rt_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_rd,
    output logic [5:0]  ex_op,
    output logic [5:0]  ex_funct,
    output logic [7:0]  ex_ctrl,
    output logic        ill_instr
);

    // ex_ctrl bit positions: {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, Branch, LinkPC, BNE}
    localparam int C_RW  = 7;
    localparam int C_MR  = 6;
    localparam int C_MW  = 5;
    localparam int C_M2R = 4;
    localparam int C_AS  = 3;
    localparam int C_BR  = 2;
    localparam int C_LNK = 1;
    localparam int C_BNE = 0;

    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm16;

    assign pc_plus4 = IF_ID[63:32];
    assign instr    = IF_ID[31:0];
    assign op       = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign funct    = instr[5:0];
    assign imm16    = instr[15:0];

    assign rf_rs_addr   = rs;
    assign rf_rt_addr   = rt;
    assign jump_address = {pc_plus4[31:28], instr[25:0], 2'b00};
    assign jr_address   = rs_data;

    logic [7:0]  ctrl_dec;
    logic [4:0]  dest;
    logic [31:0] imm_dec;
    logic        illegal;
    logic        uses_rt;
    logic        is_j;
    logic        is_jr;

    always_comb begin
        ctrl_dec = '0;
        dest     = '0;
        imm_dec  = '0;
        illegal  = 1'b0;
        uses_rt  = 1'b0;
        is_j     = 1'b0;
        is_jr    = 1'b0;
        if (instr != NOP_WORD) begin
            case (op)
                6'h00: begin
                    uses_rt = 1'b1;
                    case (funct)
                        6'h08: is_jr = 1'b1;
                        6'h09: begin
                            is_jr           = 1'b1;
                            ctrl_dec[C_RW]  = 1'b1;
                            ctrl_dec[C_LNK] = 1'b1;
                            dest            = rd;
                        end
                        6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                        6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                        6'h26, 6'h27, 6'h2a, 6'h2b: begin
                            ctrl_dec[C_RW] = 1'b1;
                            dest           = rd;
                        end
                        default: illegal = 1'b1;
                    endcase
                end
                6'h02: is_j = 1'b1;
                6'h03: begin
                    is_j            = 1'b1;
                    ctrl_dec[C_RW]  = 1'b1;
                    ctrl_dec[C_LNK] = 1'b1;
                    dest            = LINK_REG;
                end
                6'h04, 6'h05: begin
                    uses_rt         = 1'b1;
                    ctrl_dec[C_BR]  = 1'b1;
                    ctrl_dec[C_BNE] = op[0];
                    imm_dec         = {{16{imm16[15]}}, imm16};
                end
                6'h08, 6'h09, 6'h0a, 6'h0b: begin
                    ctrl_dec[C_AS] = 1'b1;
                    ctrl_dec[C_RW] = 1'b1;
                    imm_dec        = {{16{imm16[15]}}, imm16};
                    dest           = rt;
                end
                6'h0c, 6'h0d, 6'h0e: begin
                    ctrl_dec[C_AS] = 1'b1;
                    ctrl_dec[C_RW] = 1'b1;
                    imm_dec        = {16'h0000, imm16};
                    dest           = rt;
                end
                6'h0f: begin
                    ctrl_dec[C_AS] = 1'b1;
                    ctrl_dec[C_RW] = 1'b1;
                    imm_dec        = {imm16, 16'h0000};
                    dest           = rt;
                end
                6'h23: begin
                    ctrl_dec[C_MR]  = 1'b1;
                    ctrl_dec[C_M2R] = 1'b1;
                    ctrl_dec[C_RW]  = 1'b1;
                    ctrl_dec[C_AS]  = 1'b1;
                    imm_dec         = {{16{imm16[15]}}, imm16};
                    dest            = rt;
                end
                6'h2b: begin
                    uses_rt        = 1'b1;
                    ctrl_dec[C_MW] = 1'b1;
                    ctrl_dec[C_AS] = 1'b1;
                    imm_dec        = {{16{imm16[15]}}, imm16};
                end
                default: illegal = 1'b1;
            endcase
        end
        // Writes to $0 are architecturally discarded, so never request them.
        if (dest == 5'd0) begin
            ctrl_dec[C_RW] = 1'b0;
        end
    end

    logic [31:0] ex_pc_plus4_q, ex_pc_plus4_d;
    logic [31:0] ex_rs_data_q, ex_rs_data_d;
    logic [31:0] ex_rt_data_q, ex_rt_data_d;
    logic [31:0] ex_imm_q, ex_imm_d;
    logic [4:0]  ex_rs_q, ex_rs_d;
    logic [4:0]  ex_rt_q, ex_rt_d;
    logic [4:0]  ex_rd_q, ex_rd_d;
    logic [5:0]  ex_op_q, ex_op_d;
    logic [5:0]  ex_funct_q, ex_funct_d;
    logic [7:0]  ex_ctrl_q, ex_ctrl_d;
    logic        ill_q, ill_d;

    logic load_use;
    logic jr_hazard;
    logic stall;
    logic bubble;

    // Stall length falls out of where the producer sits (EX, then MEM); no FSM needed.
    assign load_use  = ex_ctrl_q[C_MR] && (ex_rt_q != 5'd0) &&
                       ((ex_rt_q == rs) || (uses_rt && (ex_rt_q == rt)));
    assign jr_hazard = is_jr && (rs != 5'd0) &&
                       ((ex_ctrl_q[C_RW] && (ex_rd_q == rs)) ||
                        (mem_reg_write && (mem_rd == rs)));
    assign stall     = load_use || jr_hazard;
    assign bubble    = ex_branch_taken || stall;

    always_comb begin
        IF_Pause = 1'b0;
        IF_Flush = 1'b0;
        id_pcsrc = 2'b00;
        if (ex_branch_taken) begin
            IF_Flush = 1'b1;
        end else if (stall) begin
            IF_Pause = 1'b1;
        end else if (is_jr) begin
            IF_Flush = 1'b1;
            id_pcsrc = 2'b10;
        end else if (is_j) begin
            IF_Flush = 1'b1;
            id_pcsrc = 2'b01;
        end
    end

    always_comb begin
        ex_pc_plus4_d = bubble ? '0 : pc_plus4;
        ex_rs_data_d  = bubble ? '0 : rs_data;
        ex_rt_data_d  = bubble ? '0 : rt_data;
        ex_imm_d      = bubble ? '0 : imm_dec;
        ex_rs_d       = bubble ? '0 : rs;
        ex_rt_d       = bubble ? '0 : rt;
        ex_rd_d       = bubble ? '0 : dest;
        ex_op_d       = bubble ? '0 : op;
        ex_funct_d    = bubble ? '0 : funct;
        ex_ctrl_d     = bubble ? '0 : ctrl_dec;
        // A stalled illegal word is re-presented, so only report it once it advances.
        ill_d         = illegal && !bubble;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_pc_plus4_q <= '0;
            ex_rs_data_q  <= '0;
            ex_rt_data_q  <= '0;
            ex_imm_q      <= '0;
            ex_rs_q       <= '0;
            ex_rt_q       <= '0;
            ex_rd_q       <= '0;
            ex_op_q       <= '0;
            ex_funct_q    <= '0;
            ex_ctrl_q     <= '0;
            ill_q         <= 1'b0;
        end else begin
            ex_pc_plus4_q <= ex_pc_plus4_d;
            ex_rs_data_q  <= ex_rs_data_d;
            ex_rt_data_q  <= ex_rt_data_d;
            ex_imm_q      <= ex_imm_d;
            ex_rs_q       <= ex_rs_d;
            ex_rt_q       <= ex_rt_d;
            ex_rd_q       <= ex_rd_d;
            ex_op_q       <= ex_op_d;
            ex_funct_q    <= ex_funct_d;
            ex_ctrl_q     <= ex_ctrl_d;
            ill_q         <= ill_d;
        end
    end

    assign ex_pc_plus4 = ex_pc_plus4_q;
    assign ex_rs_data  = ex_rs_data_q;
    assign ex_rt_data  = ex_rt_data_q;
    assign ex_imm      = ex_imm_q;
    assign ex_rs       = ex_rs_q;
    assign ex_rt       = ex_rt_q;
    assign ex_rd       = ex_rd_q;
    assign ex_op       = ex_op_q;
    assign ex_funct    = ex_funct_q;
    assign ex_ctrl     = ex_ctrl_q;
    assign ill_instr   = ill_q;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus randomized traffic
// compared against a rule-level decode/hazard model.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] IF_ID;
    logic [4:0]  rf_rs_addr, rf_rt_addr;
    logic [31:0] rs_data, rt_data;
    logic        ex_branch_taken, mem_reg_write;
    logic [4:0]  mem_rd;
    logic        IF_Pause, IF_Flush;
    logic [1:0]  id_pcsrc;
    logic [31:0] jump_address, jr_address, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [5:0]  ex_op, ex_funct;
    logic [7:0]  ex_ctrl;
    logic        ill_instr;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .reset(reset), .IF_ID(IF_ID),
        .rf_rs_addr(rf_rs_addr), .rf_rt_addr(rf_rt_addr),
        .rs_data(rs_data), .rt_data(rt_data),
        .ex_branch_taken(ex_branch_taken), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .IF_Pause(IF_Pause), .IF_Flush(IF_Flush), .id_pcsrc(id_pcsrc),
        .jump_address(jump_address), .jr_address(jr_address),
        .ex_pc_plus4(ex_pc_plus4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_op(ex_op), .ex_funct(ex_funct), .ex_ctrl(ex_ctrl), .ill_instr(ill_instr)
    );

    typedef struct packed {
        logic [7:0]  ctrl;
        logic [4:0]  dest;
        logic [31:0] imm;
        logic        ill;
        logic        uses_rt;
        logic        is_j;
        logic        is_jr;
    } dec_t;

    // Decode expressed as instruction-class rules rather than a per-opcode table.
    function automatic dec_t ref_decode(input logic [31:0] ins);
        dec_t d;
        logic [5:0] op, fn;
        logic is_r, legal, writes;
        logic [4:0] dst;
        logic [15:0] i16;
        d = '0;
        op = ins[31:26];
        fn = ins[5:0];
        i16 = ins[15:0];
        if (ins == 32'h0) return d;
        is_r = (op == 6'd0);
        legal = is_r ? (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                                   [6'h20:6'h27], 6'h2a, 6'h2b})
                     : (op inside {[6'h02:6'h05], [6'h08:6'h0f], 6'h23, 6'h2b});
        if (!legal) begin
            d.ill = 1'b1;
            return d;
        end
        d.is_j    = op inside {6'h02, 6'h03};
        d.is_jr   = is_r && (fn inside {6'h08, 6'h09});
        d.uses_rt = is_r || (op inside {6'h04, 6'h05, 6'h2b});
        writes = (is_r && fn != 6'h08) || op == 6'h03 || (op inside {[6'h08:6'h0f], 6'h23});
        dst = is_r ? ins[15:11] : ((op == 6'h03) ? 5'd31 : ins[20:16]);
        if (!writes) dst = 5'd0;
        d.dest = dst;
        if (op inside {6'h04, 6'h05, [6'h08:6'h0b], 6'h23, 6'h2b}) d.imm = 32'(signed'(i16));
        else if (op inside {[6'h0c:6'h0e]}) d.imm = {16'h0, i16};
        else if (op == 6'h0f) d.imm = {i16, 16'h0};
        d.ctrl = {writes && dst != 5'd0, op == 6'h23, op == 6'h2b, op == 6'h23,
                  (op inside {[6'h08:6'h0f], 6'h23, 6'h2b}), (op inside {6'h04, 6'h05}),
                  (op == 6'h03) || (is_r && fn == 6'h09), op == 6'h05};
        return d;
    endfunction

    task automatic apply(input logic [31:0] ins, input logic [31:0] pc4, input logic bt,
                         input logic mrw, input logic [4:0] mrd,
                         input logic [31:0] rsd, input logic [31:0] rtd);
        @(negedge clk);
        IF_ID = {pc4, ins};
        ex_branch_taken = bt;
        mem_reg_write = mrw;
        mem_rd = mrd;
        rs_data = rsd;
        rt_data = rtd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        IF_ID = '0;
        ex_branch_taken = 1'b0;
        mem_reg_write = 1'b0;
        mem_rd = '0;
        rs_data = '0;
        rt_data = '0;
        tick();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (ex_ctrl !== 8'h00) $display("FAIL rst_ctrl act=%h req=00", ex_ctrl); else passes++;
        checks++; if (ex_rd !== 5'd0) $display("FAIL rst_rd act=%0d req=0", ex_rd); else passes++;
        checks++; if (ex_pc_plus4 !== 32'h0) $display("FAIL rst_pc4 act=%h req=0", ex_pc_plus4); else passes++;
        checks++; if (ill_instr !== 1'b0) $display("FAIL rst_ill act=%b req=0", ill_instr); else passes++;
        checks++; if ({IF_Pause, IF_Flush} !== 2'b00) $display("FAIL rst_pf act=%b req=00", {IF_Pause, IF_Flush}); else passes++;
    endtask

    task automatic test_load_use();
        do_reset();
        apply(32'h8C22_0000, 32'h4, 0, 0, 0, 32'h11, 32'h22); // lw $2,0($1)
        tick();
        checks++; if (ex_ctrl !== 8'hD8) $display("FAIL lu_lwctrl act=%h req=d8", ex_ctrl); else passes++;
        apply(32'h0044_1820, 32'h8, 0, 0, 0, 32'h33, 32'h44); // add $3,$2,$4
        checks++; if ({IF_Pause, IF_Flush, id_pcsrc} !== 4'b1000) $display("FAIL lu_pause act=%b req=1000", {IF_Pause, IF_Flush, id_pcsrc}); else passes++;
        tick();
        checks++; if ({ex_ctrl, ex_rd} !== 13'h0) $display("FAIL lu_bubble act=%h/%0d req=0/0", ex_ctrl, ex_rd); else passes++;
        checks++; if (IF_Pause !== 1'b0) $display("FAIL lu_release act=%b req=0", IF_Pause); else passes++;
        tick();
        checks++; if (ex_rd !== 5'd3 || ex_ctrl !== 8'h80) $display("FAIL lu_add act=%0d/%h req=3/80", ex_rd, ex_ctrl); else passes++;
    endtask

    task automatic test_jal();
        do_reset();
        apply(32'h0C00_0100, 32'h44, 0, 0, 0, 0, 0);
        checks++; if (jump_address !== 32'h0000_0400) $display("FAIL jal_addr act=%h req=00000400", jump_address); else passes++;
        checks++; if (id_pcsrc !== 2'b01 || IF_Flush !== 1'b1) $display("FAIL jal_pc act=%b/%b req=01/1", id_pcsrc, IF_Flush); else passes++;
        tick();
        checks++; if (ex_rd !== 5'd31 || ex_ctrl[1] !== 1'b1) $display("FAIL jal_link act=%0d/%h req=31/link", ex_rd, ex_ctrl); else passes++;
        checks++; if (ex_pc_plus4 !== 32'h44) $display("FAIL jal_pc4 act=%h req=44", ex_pc_plus4); else passes++;
    endtask

    task automatic test_jr_hazard();
        do_reset();
        apply(32'h2005_0007, 32'h4, 0, 0, 0, 0, 0); // addi $5,$0,7
        tick();
        apply(32'h00A0_0008, 32'h8, 0, 0, 0, 32'h1234_5678, 0); // jr $5, producer in EX
        checks++; if (IF_Pause !== 1'b1 || id_pcsrc !== 2'b00) $display("FAIL jr_stall1 act=%b/%b req=1/00", IF_Pause, id_pcsrc); else passes++;
        tick();
        apply(32'h00A0_0008, 32'h8, 0, 1, 5, 32'h1234_5678, 0); // producer in MEM
        checks++; if (IF_Pause !== 1'b1 || IF_Flush !== 1'b0) $display("FAIL jr_stall2 act=%b/%b req=1/0", IF_Pause, IF_Flush); else passes++;
        tick();
        apply(32'h00A0_0008, 32'h8, 0, 0, 0, 32'h1234_5678, 0);
        checks++; if ({IF_Pause, IF_Flush, id_pcsrc} !== 4'b0110) $display("FAIL jr_go act=%b req=0110", {IF_Pause, IF_Flush, id_pcsrc}); else passes++;
        checks++; if (jr_address !== 32'h1234_5678) $display("FAIL jr_addr act=%h req=12345678", jr_address); else passes++;
        tick();
        checks++; if (ex_rs !== 5'd5 || ex_funct !== 6'h08) $display("FAIL jr_idex act=%0d/%h req=5/08", ex_rs, ex_funct); else passes++;
    endtask

    task automatic test_branch_squash();
        do_reset();
        apply(32'h2005_0007, 32'h4, 0, 0, 0, 0, 0);
        tick();
        apply(32'h00A0_0008, 32'h8, 1, 1, 5, 32'h55, 0);
        checks++; if ({IF_Pause, IF_Flush, id_pcsrc} !== 4'b0100) $display("FAIL bt_prio act=%b req=0100", {IF_Pause, IF_Flush, id_pcsrc}); else passes++;
        tick();
        checks++; if ({ex_ctrl, ex_rs, ex_funct, ex_pc_plus4} !== '0) $display("FAIL bt_bubble act=%h/%0d/%h req=0", ex_ctrl, ex_rs, ex_funct); else passes++;
    endtask

    task automatic test_imm();
        logic [31:0] ins [6] = '{32'h3401_FFFF, 32'h2001_FFFF, 32'h3C01_1234, 32'h1000_FFFE, 32'h1400_0001, 32'h2000_0001};
        logic [31:0] eimm[6] = '{32'h0000_FFFF, 32'hFFFF_FFFF, 32'h1234_0000, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0001};
        logic [7:0]  ectl[6] = '{8'h88, 8'h88, 8'h88, 8'h04, 8'h05, 8'h08};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            apply(ins[i], 32'h100, 0, 0, 0, 0, 0);
            tick();
            checks++; if (ex_imm !== eimm[i]) $display("FAIL imm%0d act=%h req=%h", i, ex_imm, eimm[i]); else passes++;
            checks++; if (ex_ctrl !== ectl[i]) $display("FAIL ctl%0d act=%h req=%h", i, ex_ctrl, ectl[i]); else passes++;
        end
    endtask

    task automatic test_illegal();
        do_reset();
        apply(32'hFC00_0000, 32'h4, 0, 0, 0, 0, 0);
        tick();
        checks++; if (ill_instr !== 1'b1 || ex_ctrl !== 8'h0) $display("FAIL ill_pulse act=%b/%h req=1/00", ill_instr, ex_ctrl); else passes++;
        apply(32'h0000_0000, 32'h8, 0, 0, 0, 0, 0);
        tick();
        checks++; if (ill_instr !== 1'b0 || ex_ctrl !== 8'h0) $display("FAIL ill_nop act=%b/%h req=0/00", ill_instr, ex_ctrl); else passes++;
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        apply(32'h8C22_0000, 32'h4, 0, 0, 0, 0, 0);
        tick();
        apply(32'h0044_1820, 32'h8, 0, 0, 0, 0, 0);
        checks++; if (IF_Pause !== 1'b1) $display("FAIL rms_pre act=%b req=1", IF_Pause); else passes++;
        reset = 1'b1;
        #1;
        checks++; if ({ex_ctrl, ex_rt, ex_pc_plus4} !== '0) $display("FAIL rms_clear act=%h/%0d req=0", ex_ctrl, ex_rt); else passes++;
        checks++; if (IF_Pause !== 1'b0 || IF_Flush !== 1'b0) $display("FAIL rms_pause act=%b/%b req=0/0", IF_Pause, IF_Flush); else passes++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_random();
        logic [5:0]  ops[16] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                                 6'h09, 6'h0c, 6'h0f, 6'h23, 6'h23, 6'h2b, 6'h3f, 6'h11};
        logic [5:0]  fns[8]  = '{6'h20, 6'h21, 6'h22, 6'h08, 6'h09, 6'h2a, 6'h00, 6'h3f};
        logic [7:0]  m_ctrl = '0;
        logic [4:0]  m_rt = '0, m_rd = '0;
        logic [31:0] ins, pc4, rsd, rtd;
        logic [5:0]  op;
        logic        bt, mrw, lu, jh, stall, bub, e_pause, e_flush;
        logic [4:0]  mrd;
        logic [1:0]  e_pc;
        dec_t        d;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            op = ops[$urandom_range(0, 15)];
            if (op == 6'h00)
                ins = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       5'd0, fns[$urandom_range(0, 7)]};
            else
                ins = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
            if ($urandom_range(0, 15) == 0) ins = 32'h0;
            pc4 = $urandom & 32'hFFFF_FFFC;
            rsd = $urandom;
            rtd = $urandom;
            bt  = ($urandom_range(0, 7) == 0);
            mrw = 1'($urandom);
            mrd = 5'($urandom_range(0, 3));
            apply(ins, pc4, bt, mrw, mrd, rsd, rtd);
            d  = ref_decode(ins);
            lu = m_ctrl[6] && m_rt != 0 && (m_rt == ins[25:21] || (d.uses_rt && m_rt == ins[20:16]));
            jh = d.is_jr && ins[25:21] != 0 &&
                 ((m_ctrl[7] && m_rd == ins[25:21]) || (mrw && mrd == ins[25:21]));
            stall   = lu || jh;
            bub     = bt || stall;
            e_pause = !bt && stall;
            e_flush = bt || (!stall && (d.is_j || d.is_jr));
            e_pc    = bub ? 2'b00 : (d.is_jr ? 2'b10 : (d.is_j ? 2'b01 : 2'b00));
            checks++; if ({IF_Pause, IF_Flush} !== {e_pause, e_flush}) $display("FAIL r%0d_pf act=%b req=%b ins=%h", n, {IF_Pause, IF_Flush}, {e_pause, e_flush}, ins); else passes++;
            checks++; if (id_pcsrc !== e_pc) $display("FAIL r%0d_pcsrc act=%b req=%b ins=%h", n, id_pcsrc, e_pc, ins); else passes++;
            checks++; if (jump_address !== {pc4[31:28], ins[25:0], 2'b00}) $display("FAIL r%0d_jaddr act=%h ins=%h", n, jump_address, ins); else passes++;
            checks++; if (jr_address !== rsd || rf_rs_addr !== ins[25:21] || rf_rt_addr !== ins[20:16]) $display("FAIL r%0d_rf act=%h/%0d/%0d req=%h", n, jr_address, rf_rs_addr, rf_rt_addr, rsd); else passes++;
            tick();
            m_ctrl = bub ? 8'h0 : d.ctrl;
            m_rt   = bub ? 5'd0 : ins[20:16];
            m_rd   = bub ? 5'd0 : d.dest;
            checks++; if (ex_ctrl !== m_ctrl) $display("FAIL r%0d_ctrl act=%h req=%h ins=%h", n, ex_ctrl, m_ctrl, ins); else passes++;
            checks++; if (ex_rd !== m_rd || ex_rt !== m_rt) $display("FAIL r%0d_regs act=%0d/%0d req=%0d/%0d", n, ex_rd, ex_rt, m_rd, m_rt); else passes++;
            checks++; if (ex_imm !== (bub ? 32'h0 : d.imm)) $display("FAIL r%0d_imm act=%h req=%h ins=%h", n, ex_imm, bub ? 32'h0 : d.imm, ins); else passes++;
            checks++; if (ex_rs_data !== (bub ? 32'h0 : rsd) || ex_rt_data !== (bub ? 32'h0 : rtd)) $display("FAIL r%0d_data act=%h/%h", n, ex_rs_data, ex_rt_data); else passes++;
            checks++; if (ex_pc_plus4 !== (bub ? 32'h0 : pc4) || ex_op !== (bub ? 6'h0 : ins[31:26])) $display("FAIL r%0d_pc4op act=%h/%h", n, ex_pc_plus4, ex_op); else passes++;
            checks++; if (ill_instr !== (d.ill && !bub)) $display("FAIL r%0d_ill act=%b req=%b ins=%h", n, ill_instr, d.ill && !bub, ins); else passes++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        IF_ID = '0;
        ex_branch_taken = 1'b0;
        mem_reg_write = 1'b0;
        mem_rd = '0;
        rs_data = '0;
        rt_data = '0;
        test_reset();
        test_load_use();
        test_jal();
        test_jr_hazard();
        test_branch_squash();
        test_imm();
        test_illegal();
        test_reset_mid_stall();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
